sc_par_bs_decode: RTL and testbench

// - Parallel stochastic-to-binary decoder for an m x n array of stochastic bitstreams.
// - Sits downstream of the parallel stochastic edge-detection array.
// - Counts the ones in each pixel's output stream over a fixed window of LEN cycles.
// - Presents one binary magnitude per pixel, with a one-cycle valid pulse per frame.
//

---
 rtl/sc_par_bs_decode.sv | 151 +++++++++++++++
 tb/tb_sc_par_bs_decode.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_par_bs_decode.sv
// sc_par_bs_decode
//
// Parallel stochastic-to-binary decoder. Each of the m*n pixel bitstreams
// coming out of the stochastic edge-detection array is integrated over a
// window of LEN clock cycles. The resulting ones-count, 0..LEN inclusive, is
// the binary magnitude of that pixel. Each completed window updates every
// pixel output at the same time and raises valid for one cycle.
//
// Ports
//   clk      in   1           rising-edge clock
//   reset    in   1           synchronous, active-high; overrides everything
//   start    in   1           begin a window; only looked at while idle
//   s        in   m*n         per-pixel stochastic bit, pixel (i,j) at i*n+j
//   pix_out  out  m*n*CW      per-pixel count of the last completed window,
//                             pixel k occupies bits [k*CW +: CW]
//   valid    out  1           one-cycle pulse: pix_out was just updated
//   busy     out  1           high while a window is being accumulated
//
// Timing: when start is seen at edge t, the bits presented at edges
// t+1..t+LEN are counted. valid is high in the cycle after edge t+LEN. A
// start in that valid cycle opens the next window with no gap cycle.
//
// With EDGE_MASK set, the last row and the last column are not driven by the
// upstream array. Their inputs are replaced by a constant 0, so an X on them
// can never reach an accumulator or an output.

module sc_par_bs_decode #(
  parameter int m         = 32,
  parameter int n         = 32,
  parameter int LEN       = 256,
  parameter int CW        = $clog2(LEN + 1),
  parameter bit EDGE_MASK = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [m*n-1:0]      s,
  output logic [m*n*CW-1:0]   pix_out,
  output logic                valid,
  output logic                busy
);

  localparam int NPIX = m * n;
  // The window position counter only needs to reach LEN-1.
  localparam int TW   = $clog2(LEN);

  localparam logic [TW-1:0] LAST_TICK = TW'(LEN - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   tick_r;
  logic [CW-1:0]   acc_r [NPIX];
  logic [CW-1:0]   pix_r [NPIX];
  logic            valid_r;
  logic            busy_r;

  // Effective per-pixel input bit after masking, and next accumulator value.
  logic [NPIX-1:0] bit_s;
  logic [CW-1:0]   sum_s [NPIX];

  for (genvar k = 0; k < NPIX; k++) begin : g_pix
    // Pixels on the undriven border are tied off when masking is enabled.
    localparam bit MASKED = EDGE_MASK && (((k / n) == (m - 1)) || ((k % n) == (n - 1)));

    if (MASKED) begin : g_masked
      // The input is deliberately left unconnected to the datapath.
      logic unused_bit_s;
      assign unused_bit_s = s[k];
      assign bit_s[k]     = 1'b0;
    end else begin : g_live
      assign bit_s[k] = s[k];
    end

    // The count cannot exceed LEN, and CW holds LEN, so the sum never wraps.
    assign sum_s[k] = acc_r[k] + {{(CW-1){1'b0}}, bit_s[k]};

    assign pix_out[k*CW +: CW] = pix_r[k];
  end

  assign valid = valid_r;
  assign busy  = busy_r;

  // Frame FSM, per-pixel accumulators and the registered result bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      tick_r  <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      for (int k = 0; k < NPIX; k++) begin
        acc_r[k] <= '0;
        pix_r[k] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          // valid lasts one cycle. A start in the valid cycle is taken here,
          // which gives back-to-back windows.
          valid_r <= 1'b0;
          tick_r  <= '0;
          if (start) begin
            for (int k = 0; k < NPIX; k++) begin
              acc_r[k] <= '0;
            end
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end

        RUN: begin
          // start is not looked at here, so a window cannot be restarted.
          for (int k = 0; k < NPIX; k++) begin
            acc_r[k] <= sum_s[k];
          end
          if (tick_r == LAST_TICK) begin
            // The final sample goes straight into the result through sum_s.
            // This avoids an extra cycle of latency.
            for (int k = 0; k < NPIX; k++) begin
              pix_r[k] <= sum_s[k];
            end
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
            tick_r  <= '0;
            state_r <= IDLE;
          end else begin
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
            tick_r  <= tick_r + TICK_ONE;
            state_r <= RUN;
          end
        end

        default: begin
          state_r <= IDLE;
          tick_r  <= '0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_par_bs_decode.sv
// Directed testbench for sc_par_bs_decode (m=n=4, LEN=16, CW=5).
// Two instances share the stimulus: one with edge masking enabled and one
// with masking disabled.

module tb_sc_par_bs_decode;

  localparam int M    = 4;
  localparam int N    = 4;
  localparam int LEN  = 16;
  localparam int CW   = 5;
  localparam int NPIX = M * N;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [NPIX-1:0]      s;
  logic [NPIX*CW-1:0]   pix_m;
  logic [NPIX*CW-1:0]   pix_u;
  logic                 valid_m;
  logic                 busy_m;
  logic                 valid_u;
  logic                 busy_u;

  int checks = 0;
  int errors = 0;

  // stream[k][c-1] is the bit that pixel k presents in sampled cycle c.
  logic [LEN-1:0] stream [NPIX];
  // Expected pixel counts for the masked instance.
  int             exp_pix [NPIX];

  always #5 clk = ~clk;

  sc_par_bs_decode #(.m(M), .n(N), .LEN(LEN), .CW(CW), .EDGE_MASK(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .s       (s),
    .pix_out (pix_m),
    .valid   (valid_m),
    .busy    (busy_m)
  );

  sc_par_bs_decode #(.m(M), .n(N), .LEN(LEN), .CW(CW), .EDGE_MASK(1'b0)) dut_nomask (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .s       (s),
    .pix_out (pix_u),
    .valid   (valid_u),
    .busy    (busy_u)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_streams();
    for (int k = 0; k < NPIX; k++) begin
      stream[k]  = '0;
      exp_pix[k] = 0;
    end
  endtask

  task automatic check_pix(input string tag);
    for (int k = 0; k < NPIX; k++) begin
      check_val($sformatf("%s_pix%0d", tag, k), int'(pix_m[k*CW +: CW]), exp_pix[k]);
    end
  endtask

  // Called in cycle 0 of a window. It asserts start, then drives sampled
  // cycles 1..LEN. It returns in cycle LEN+1, the expected valid cycle.
  task automatic drive_frame(input logic [LEN:0] extra_start, input int hold_k, input int hold_v);
    start = 1'b1;
    s     = '0;
    step();
    for (int c = 1; c <= LEN; c++) begin
      check_val($sformatf("busy_c%0d", c), int'(busy_m), 1);
      check_val($sformatf("valid_c%0d", c), int'(valid_m), 0);
      if (hold_k >= 0) begin
        check_val($sformatf("hold_c%0d", c), int'(pix_m[hold_k*CW +: CW]), hold_v);
      end
      start = extra_start[c];
      for (int k = 0; k < NPIX; k++) begin
        s[k] = stream[k][c-1];
      end
      step();
    end
    start = 1'b0;
    s     = '0;
  endtask

  initial begin
    logic [LEN:0] no_extra;
    logic [LEN:0] repulse;
    bit           seen_valid;

    no_extra = '0;
    repulse  = '0;
    repulse[4]  = 1'b1;
    repulse[10] = 1'b1;

    reset = 1'b1;
    start = 1'b1;  // reset must win over start
    s     = '1;
    clear_streams();
    step();
    step();
    check_val("rst_busy", int'(busy_m), 0);
    check_val("rst_valid", int'(valid_m), 0);
    check_pix("rst");
    reset = 1'b0;
    start = 1'b0;
    s     = '0;
    step();
    check_val("idle_busy", int'(busy_m), 0);

    // 1. Full stream on pixel 0.
    clear_streams();
    stream[0]  = 16'hFFFF;
    exp_pix[0] = 16;
    drive_frame(no_extra, -1, 0);
    check_val("s1_valid", int'(valid_m), 1);
    check_val("s1_busy", int'(busy_m), 0);
    check_pix("s1");
    step();
    check_val("s1_valid_drop", int'(valid_m), 0);
    check_val("s1_hold", int'(pix_m[0 +: CW]), 16);

    // 2. Alternating stream, then only the last sampled bit set.
    clear_streams();
    stream[5]  = 16'h5555;
    exp_pix[5] = 8;
    drive_frame(no_extra, -1, 0);
    check_val("s2a_valid", int'(valid_m), 1);
    check_pix("s2a");
    step();
    clear_streams();
    stream[5]  = 16'h8000;
    exp_pix[5] = 1;
    drive_frame(no_extra, -1, 0);
    check_val("s2b_valid", int'(valid_m), 1);
    check_pix("s2b");
    step();

    // 3. Border pixels driven high: masked instance reads 0, unmasked reads 16.
    clear_streams();
    stream[3]  = 16'hFFFF;
    stream[12] = 16'hFFFF;
    stream[15] = 16'hFFFF;
    stream[0]  = 16'h0003;
    exp_pix[0] = 2;
    drive_frame(no_extra, -1, 0);
    check_val("s3_valid", int'(valid_m), 1);
    check_pix("s3");
    check_val("s3_nm_valid", int'(valid_u), 1);
    check_val("s3_nm_pix3", int'(pix_u[3*CW +: CW]), 16);
    check_val("s3_nm_pix12", int'(pix_u[12*CW +: CW]), 16);
    check_val("s3_nm_pix15", int'(pix_u[15*CW +: CW]), 16);
    check_val("s3_nm_pix0", int'(pix_u[0 +: CW]), 2);
    step();

    // 4. start re-pulsed in cycles 4 and 10 of RUN.
    clear_streams();
    stream[0]  = 16'hFFFF;
    exp_pix[0] = 16;
    drive_frame(repulse, -1, 0);
    check_val("s4_valid", int'(valid_m), 1);
    check_pix("s4");
    for (int c = 0; c < 3; c++) begin
      step();
      check_val($sformatf("s4_novalid%0d", c), int'(valid_m), 0);
      check_val($sformatf("s4_idle%0d", c), int'(busy_m), 0);
    end

    // 5. Reset in cycle 6 of RUN aborts the window.
    start = 1'b1;
    s     = '0;
    step();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      s[0] = 1'b1;
      step();
    end
    reset = 1'b1;
    s[0]  = 1'b1;
    step();
    reset = 1'b0;
    s     = '0;
    clear_streams();
    check_val("s5_busy", int'(busy_m), 0);
    check_val("s5_valid", int'(valid_m), 0);
    check_pix("s5_cleared");
    seen_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (valid_m) seen_valid = 1'b1;
      step();
    end
    check_val("s5_no_late_valid", int'(seen_valid), 0);
    stream[0]  = 16'h0F0F;
    stream[6]  = 16'h8001;
    exp_pix[0] = 8;
    exp_pix[6] = 2;
    drive_frame(no_extra, -1, 0);
    check_val("s5_new_valid", int'(valid_m), 1);
    check_pix("s5_new");
    step();

    // 6. Back-to-back frames with start held in the valid cycle.
    clear_streams();
    stream[0]  = 16'hFFFF;
    exp_pix[0] = 16;
    drive_frame(no_extra, -1, 0);
    check_val("s6a_valid", int'(valid_m), 1);
    check_pix("s6a");
    clear_streams();
    drive_frame(no_extra, 0, 16);
    check_val("s6b_valid", int'(valid_m), 1);
    check_pix("s6b");
    step();
    check_val("s6b_valid_drop", int'(valid_m), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
